// File: rtl/int_controller.sv
`default_nettype none
// ============================================================================
// int_controller : edge-latched, priority-selected interrupt source that
//                  drains the pipeline, redirects to a vector, returns to EPC.
// Rev 1.0
// ============================================================================
module int_controller #(
  parameter int          NUM_IRQ      = 8,
  parameter logic [31:0] VECTOR_BASE  = 32'h0000_0100,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               ien_we,
  input  logic [NUM_IRQ-1:0] ien_wdata,
  input  logic               branch,
  input  logic [31:0]        resume_pc,
  input  logic               mret_mem,
  output logic               int_set_pl_pause,
  output logic               int_flag,
  output logic [31:0]        nextpc_int,
  output logic [31:0]        epc,
  output logic [4:0]         int_cause,
  output logic               in_service
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PAUSE = 3'd1;
  localparam logic [2:0] S_JUMP  = 3'd2;
  localparam logic [2:0] S_INSVC = 3'd3;
  localparam logic [2:0] S_RET   = 3'd4;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_ien;
  logic [NUM_IRQ-1:0] r_irq_q;
  logic [3:0]         r_cnt;
  logic [31:0]        r_epc;
  logic [4:0]         r_cause;

  logic [NUM_IRQ-1:0] w_edges;
  logic [NUM_IRQ-1:0] w_eligible;
  logic [NUM_IRQ-1:0] w_clear_mask;
  logic [4:0]         w_sel;
  logic               w_req;
  logic               w_accept;
  logic               w_drain_done;

  assign w_edges      = irq & ~r_irq_q;
  assign w_eligible   = r_pending & r_ien;
  assign w_req        = |w_eligible;
  // A resolving branch would overwrite the redirect, so acceptance waits for it.
  assign w_accept     = (r_state == S_IDLE) && w_req && !branch;
  assign w_drain_done = (r_state == S_PAUSE) && (r_cnt == 4'd0);

  always_comb begin
    w_sel = 5'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_sel = 5'(i);
    end
  end

  always_comb begin
    w_clear_mask = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_clear_mask[i] = w_accept && (w_sel == 5'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_PAUSE;
      S_PAUSE: if (w_drain_done) w_next_state = S_JUMP;
      S_JUMP:  w_next_state = S_INSVC;
      S_INSVC: if (mret_mem) w_next_state = S_RET;
      S_RET:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    int_set_pl_pause = 1'b0;
    int_flag         = 1'b0;
    nextpc_int       = 32'd0;
    in_service       = 1'b0;
    case (r_state)
      S_PAUSE: int_set_pl_pause = 1'b1;
      S_JUMP: begin
        int_flag   = 1'b1;
        nextpc_int = VECTOR_BASE + {25'd0, r_cause, 2'b00};
      end
      S_INSVC: in_service = 1'b1;
      S_RET: begin
        int_flag   = 1'b1;
        nextpc_int = r_epc;
      end
      default: ;
    endcase
  end

  // New edges win over the acceptance clear so a re-raised line is never lost.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_pending <= '0;
      r_ien     <= '0;
      r_irq_q   <= '0;
      r_cnt     <= 4'd0;
      r_epc     <= 32'd0;
      r_cause   <= 5'd0;
    end else begin
      r_irq_q   <= irq;
      r_pending <= (r_pending & ~w_clear_mask) | w_edges;
      if (ien_we) r_ien <= ien_wdata;
      if (w_accept) begin
        r_cause <= w_sel;
        r_cnt   <= DRAIN_LAST;
      end else if ((r_state == S_PAUSE) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_drain_done) r_epc <= resume_pc;
    end
  end

  assign epc       = r_epc;
  assign int_cause = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_int_controller.sv
`default_nettype none
// Testbench for int_controller: directed vector table, hand-written corner
// sequences and randomized traffic checked against a cycle-age reference model.
module tb_int_controller;

  localparam int          N  = 8;
  localparam logic [31:0] VB = 32'h0000_0100;
  localparam int          D  = 3;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic [N-1:0] irq = '0;
  logic         ien_we = 1'b0;
  logic [N-1:0] ien_wdata = '0;
  logic         branch = 1'b0;
  logic [31:0]  resume_pc = 32'd0;
  logic         mret_mem = 1'b0;
  logic         pause, flag, insvc;
  logic [31:0]  npc, epc;
  logic [4:0]   cause;

  int n_checks = 0;
  int n_err    = 0;

  int_controller #(.NUM_IRQ(N), .VECTOR_BASE(VB), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .clr(clr), .irq(irq), .ien_we(ien_we), .ien_wdata(ien_wdata),
    .branch(branch), .resume_pc(resume_pc), .mret_mem(mret_mem),
    .int_set_pl_pause(pause), .int_flag(flag), .nextpc_int(npc),
    .epc(epc), .int_cause(cause), .in_service(insvc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: an accepted interrupt is tracked by its age in cycles.
  // Ages 0..D-1 drain, age D redirects to the vector, later ages are in service.
  bit [N-1:0] m_pend, m_ien, m_irqq;
  bit         m_busy, m_ret;
  int         m_age;
  bit [31:0]  m_epc;
  bit [4:0]   m_cause;

  always @(posedge clk) begin : model
    bit [N-1:0] edges, en, clrm;
    edges = irq & ~m_irqq;
    clrm  = '0;
    if (clr) begin
      m_pend = '0; m_ien = '0; m_irqq = '0; m_busy = 0; m_ret = 0;
      m_age = 0; m_epc = '0; m_cause = '0;
    end else begin
      if (m_ret) begin
        m_ret = 0;
      end else if (m_busy) begin
        if (m_age == D - 1) m_epc = resume_pc;
        if (m_age <= D) m_age++;
        else if (mret_mem) begin
          m_busy = 0;
          m_ret  = 1;
        end
      end else begin
        en = m_pend & m_ien;
        if (en != 0 && !branch) begin
          for (int i = N - 1; i >= 0; i--) if (en[i]) m_cause = 5'(i);
          clrm[m_cause] = 1'b1;
          m_busy = 1;
          m_age  = 0;
        end
      end
      m_pend = (m_pend & ~clrm) | edges;
      m_irqq = irq;
      if (ien_we) m_ien = ien_wdata;
    end
  end

  always @(negedge clk) begin : model_check
    logic [31:0] e_npc;
    e_npc = (m_busy && m_age == D) ? VB + 32'(m_cause) * 4 : (m_ret ? m_epc : 32'd0);
    chk("model_pause", 32'(pause), 32'(m_busy && m_age < D));
    chk("model_flag",  32'(flag),  32'((m_busy && m_age == D) || m_ret));
    chk("model_npc",   npc, e_npc);
    chk("model_epc",   epc, m_epc);
    chk("model_cause", 32'(cause), 32'(m_cause));
    chk("model_insvc", 32'(insvc), 32'(m_busy && m_age > D));
  end

  typedef struct {
    logic        clr;
    logic [7:0]  irq;
    logic        ien_we;
    logic [7:0]  ien_wdata;
    logic        mret;
    logic        pause;
    logic        flag;
    logic [31:0] npc;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic        insvc;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  5'd0, 1'b0};
    vecs[1]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  5'd0, 1'b0};
    vecs[2]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  5'd0, 1'b0};
    vecs[3]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  5'd0, 1'b0};
    vecs[4]  = '{1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  5'd0, 1'b0};
    vecs[5]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  5'd0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  5'd0, 1'b0};
    vecs[7]  = '{1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,  5'd0, 1'b0};
    vecs[8]  = '{1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,  5'd2, 1'b0};
    vecs[9]  = '{1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,  5'd2, 1'b0};
    vecs[10] = '{1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0,  5'd2, 1'b0};
    vecs[11] = '{1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b0, 1'b1, 32'h108, 32'h40, 5'd2, 1'b0};
    vecs[12] = '{1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 32'h0,   32'h40, 5'd2, 1'b1};
    vecs[13] = '{1'b0, 8'h04, 1'b0, 8'h04, 1'b1, 1'b0, 1'b1, 32'h40,  32'h40, 5'd2, 1'b0};
    vecs[14] = '{1'b0, 8'h04, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 32'h0,   32'h40, 5'd2, 1'b0};

    // Reset with lines high, then the basic vectored entry and return.
    resume_pc = 32'h40;
    for (int v = 0; v < 15; v++) begin
      clr = vecs[v].clr; irq = vecs[v].irq; ien_we = vecs[v].ien_we;
      ien_wdata = vecs[v].ien_wdata; mret_mem = vecs[v].mret;
      step();
      chk($sformatf("vec%0d_pause", v), 32'(pause), 32'(vecs[v].pause));
      chk($sformatf("vec%0d_flag", v),  32'(flag),  32'(vecs[v].flag));
      chk($sformatf("vec%0d_npc", v),   npc,        vecs[v].npc);
      chk($sformatf("vec%0d_epc", v),   epc,        vecs[v].epc);
      chk($sformatf("vec%0d_cause", v), 32'(cause), 32'(vecs[v].cause));
      chk($sformatf("vec%0d_insvc", v), 32'(insvc), 32'(vecs[v].insvc));
    end
    ien_we = 1'b0; mret_mem = 1'b0;

    // Priority under a mask; the masked line stays pending until enabled.
    clr = 1'b1; irq = '0; step();
    clr = 1'b0; ien_we = 1'b1; ien_wdata = 8'hF0; step(); ien_we = 1'b0;
    irq = 8'h22; step();
    step(); chk("prio_pause", 32'(pause), 32'd1); chk("prio_cause", 32'(cause), 32'd5);
    step(); step(); step();
    chk("prio_flag", 32'(flag), 32'd1); chk("prio_vec", npc, 32'h114);
    step(); chk("prio_insvc", 32'(insvc), 32'd1);
    mret_mem = 1'b1; step(); mret_mem = 1'b0; chk("prio_ret_flag", 32'(flag), 32'd1);
    ien_we = 1'b1; ien_wdata = 8'hFF; step(); ien_we = 1'b0;
    chk("prio_idle", 32'(pause), 32'd0);
    step(); chk("prio2_pause", 32'(pause), 32'd1); chk("prio2_cause", 32'(cause), 32'd1);
    step(); step(); step();
    chk("prio2_flag", 32'(flag), 32'd1); chk("prio2_vec", npc, 32'h104);
    step(); mret_mem = 1'b1; step(); mret_mem = 1'b0; step();

    // Branch deferral, then a return racing a fresh edge on line 0.
    clr = 1'b1; irq = '0; step();
    clr = 1'b0; ien_we = 1'b1; ien_wdata = 8'h01; resume_pc = 32'h200; step(); ien_we = 1'b0;
    irq = 8'h01; step();
    branch = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); chk($sformatf("br_hold%0d", k), 32'(pause), 32'd0);
    end
    branch = 1'b0; step(); chk("br_pause", 32'(pause), 32'd1);
    step(); step(); step();
    chk("br_flag", 32'(flag), 32'd1); chk("br_vec", npc, 32'h100);
    step(); chk("ret_insvc", 32'(insvc), 32'd1);
    irq = 8'h00; step();
    irq = 8'h01; mret_mem = 1'b1; step(); mret_mem = 1'b0;
    chk("ret_flag", 32'(flag), 32'd1); chk("ret_npc", npc, 32'h200);
    step();
    chk("ret_idle_pause", 32'(pause), 32'd0); chk("ret_idle_insvc", 32'(insvc), 32'd0);
    chk("ret_idle_flag", 32'(flag), 32'd0);
    step(); chk("ret_retake_pause", 32'(pause), 32'd1); chk("ret_retake_cause", 32'(cause), 32'd0);

    // Reset in the second drain cycle aborts with no redirect.
    clr = 1'b1; irq = '0; step();
    clr = 1'b0; ien_we = 1'b1; ien_wdata = 8'h08; step(); ien_we = 1'b0;
    irq = 8'h08; step();
    step(); chk("abort_p1", 32'(pause), 32'd1);
    step(); chk("abort_p2", 32'(pause), 32'd1);
    clr = 1'b1; irq = '0; step();
    chk("abort_pause", 32'(pause), 32'd0); chk("abort_flag", 32'(flag), 32'd0);
    clr = 1'b0; ien_we = 1'b1; ien_wdata = 8'hFF; step(); ien_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("abort_quiet_pause%0d", k), 32'(pause), 32'd0);
      chk($sformatf("abort_quiet_flag%0d", k), 32'(flag), 32'd0);
    end

    // Randomized traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) irq = 8'($urandom);
      ien_we    = ($urandom_range(0, 15) == 0);
      ien_wdata = 8'($urandom);
      branch    = ($urandom_range(0, 3) == 0);
      mret_mem  = ($urandom_range(0, 5) == 0);
      clr       = ($urandom_range(0, 199) == 0);
      resume_pc = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
